msrv32_iadder_pipe: RTL and testbench
=====================================

MSRV32_IADDER_PIPE -- requirements
Module: msrv32_iadder_pipe

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; even values only, minimum 8.
REQ-002 Parameter IALIGN, default 4: instruction alignment in bytes; legal values 2 or 4.
REQ-003 Parameter SPLIT_ADD, default 1: 1 = carry-split add across two stages; 0 = full add in stage 1.
REQ-004 ms_riscv32_mp_clk_in  in  1  sole clock, rising edge.
REQ-005 ms_riscv32_mp_rst_in  in  1  asynchronous, active-high reset.
REQ-006 pc_in  in  XLEN  program counter operand.
REQ-007 rs_1_in  in  XLEN  register operand.
REQ-008 imm_in  in  XLEN  sign-extended immediate.
REQ-009 iadder_src_in  in  1  base select: 0 = pc_in, 1 = rs_1_in.
REQ-010 jalr_in  in  1  1 = clear result bit 0 (JALR target rule).
REQ-011 chk_align_in  in  1  1 = evaluate misalignment for this request.
REQ-012 valid_in  in  1  request valid.
REQ-013 ready_out  out  1  block accepts a request this cycle.
REQ-014 flush_in  in  1  discard all in-flight and same-cycle requests.
REQ-015 iadder_out  out  XLEN  computed address.
REQ-016 misaligned_out  out  1  result violates IALIGN while chk_align was set.
REQ-017 valid_out  out  1  iadder_out/misaligned_out valid.
REQ-018 ready_in  in  1  downstream accepts the result.

Function
REQ-019 Transfer in occurs on valid_in && ready_out && !flush_in; transfer out occurs on valid_out && ready_in.
REQ-020 Latency is exactly 2 cycles from input transfer to valid_out with no backpressure, for both SPLIT_ADD values.
REQ-021 Stage 1 SHALL register base = iadder_src_in ? rs_1_in : pc_in, together with imm_in, jalr_in and chk_align_in.
REQ-022 With SPLIT_ADD=1, stage 1 SHALL add the low XLEN/2 bits and register the sum and carry; stage 2 SHALL add the high halves plus the carry.
REQ-023 With SPLIT_ADD=0, stage 1 SHALL register the full sum, and stage 2 SHALL only apply the post-processing.
REQ-024 Sum is modulo 2^XLEN; carry out of the MSB is discarded (wrap-around, no flag).
REQ-025 If jalr_in=1, result bit 0 SHALL be forced to 0 before the alignment check.
REQ-026 misaligned_out = chk_align && (result[1:0] != 0) for IALIGN=4; for IALIGN=2 it is chk_align && result[0].
REQ-027 Each stage holds its contents while its downstream is not ready; ready_out = !s1_valid || s2_can_accept, where s2_can_accept = !s2_valid || ready_in.
REQ-028 Full pipeline with ready_in=1 SHALL sustain one transfer per cycle; with ready_in=0 it holds 2 entries, ready_out=0, and outputs stable.
REQ-029 Data in a stage SHALL change only on a transfer into that stage; no entry is duplicated or dropped.
REQ-030 flush_in=1 SHALL clear both stage valid bits at the next edge and block capture of any same-cycle valid_in; flush has priority over all transfers.
REQ-031 When valid_out=0, iadder_out and misaligned_out hold their last values (don't-care for checking).

Reset
REQ-032 Reset SHALL asynchronously clear both stage valid bits: valid_out=0, ready_out=1, iadder_out=0, misaligned_out=0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight requests; the first request after deassertion completes normally in 2 cycles.

Structure
REQ-034 Shared package msrv32_pkg SHALL hold XLEN and IALIGN defaults and named constants for the base-select encoding (BASE_PC=0, BASE_RS1=1).
REQ-035 One sub-module, msrv32_pipe_stage (parametrised-width valid/ready register slice with flush), SHALL be instantiated twice.

Verification
REQ-036 pc=0x0000_1000, imm=0x0000_0010, src=0, jalr=0, chk=1 -> 2 cycles later iadder_out=0x0000_1010, misaligned=0.
REQ-037 rs1=0x0000_2003, imm=0x0000_0000, src=1, jalr=1, chk=1, IALIGN=4 -> iadder_out=0x0000_2002, misaligned=1; same request with IALIGN=2 -> misaligned=0.
REQ-038 pc=0x0000_FFFF, imm=0x0000_0001 with SPLIT_ADD=1 -> 0x0001_0000 (cross-half carry); pc=0xFFFF_FFFC, imm=0x8 -> 0x0000_0004 (wrap).
REQ-039 Three back-to-back requests with ready_in held 0 for 3 cycles -> ready_out drops after 2 accepted; on release, results emerge in order, none lost.
REQ-040 flush_in pulsed with 2 in flight plus a same-cycle valid_in -> valid_out=0 the next cycle, no stale output ever appears.
REQ-041 Reset asserted with a full pipeline -> valid_out=0 immediately; the first post-reset request emerges after exactly 2 cycles.

Source files
------------

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared widths, base-select encoding and alignment helper
// No ports: imported by msrv32_pipe_stage and msrv32_iadder_pipe.
package msrv32_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int IALIGN_DEFAULT = 4;

  localparam logic BASE_PC  = 1'b0;
  localparam logic BASE_RS1 = 1'b1;

  // A 2-byte aligned target only needs bit 0 clear; 4-byte needs both low bits clear.
  function automatic logic addr_misaligned(input logic [1:0] lsb, input logic chk, input int ialign);
    return chk && ((ialign == 2) ? lsb[0] : (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/msrv32_pipe_stage.sv
// rtl/msrv32_pipe_stage.sv - one valid/ready register slice with flush
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   flush_i                drop held entry and refuse capture this cycle
//   in_valid_i/in_data_i   upstream request, in_ready_o accepts it
//   out_valid_o/out_data_o held entry, out_ready_i lets it leave
module msrv32_pipe_stage
  import msrv32_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  // Accept when empty, or when the held entry leaves in the same cycle.
  assign in_ready_o = !valid_q || out_ready_i;
  assign load       = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (in_ready_o) begin
      valid_d = in_valid_i;
    end
    // Payload only moves on a real transfer so the output holds when idle.
    if (load) begin
      data_d = in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/msrv32_iadder_pipe.sv
// rtl/msrv32_iadder_pipe.sv - two-stage address adder with JALR masking and alignment check
// Ports:
//   ms_riscv32_mp_clk_in, ms_riscv32_mp_rst_in   clock, asynchronous active-high reset
//   pc_in, rs_1_in, imm_in, iadder_src_in        operands and base select
//   jalr_in, chk_align_in                        bit-0 clear and misalignment enable
//   valid_in/ready_out, flush_in                 request handshake and pipeline flush
//   iadder_out, misaligned_out, valid_out/ready_in   result handshake
module msrv32_iadder_pipe
  import msrv32_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int IALIGN    = IALIGN_DEFAULT,
  parameter int SPLIT_ADD = 1
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs_1_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            iadder_src_in,
  input  logic            jalr_in,
  input  logic            chk_align_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic            flush_in,
  output logic [XLEN-1:0] iadder_out,
  output logic            misaligned_out,
  output logic            valid_out,
  input  logic            ready_in
);

  localparam int H   = XLEN / 2;
  // Split payload: {base_hi, imm_hi, carry, sum_lo, jalr, chk}; full payload: {sum, jalr, chk}.
  localparam int S1W = (SPLIT_ADD != 0) ? (3 * H + 3) : (XLEN + 2);
  localparam int S2W = XLEN + 1;

  logic [XLEN-1:0] base;
  logic [S1W-1:0]  s1_d, s1_q;
  logic            s1_valid;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] result;
  logic            mis;
  logic [S2W-1:0]  s2_d, s2_q;
  logic            s2_in_ready;

  assign base = (iadder_src_in == BASE_RS1) ? rs_1_in : pc_in;

  generate
    if (SPLIT_ADD != 0) begin : g_split
      logic [H:0] lo_sum;
      logic [H-1:0] hi_sum;
      assign lo_sum = {1'b0, base[H-1:0]} + {1'b0, imm_in[H-1:0]};
      assign s1_d   = {base[XLEN-1:H], imm_in[XLEN-1:H], lo_sum, jalr_in, chk_align_in};
      assign hi_sum = s1_q[3*H+2 -: H] + s1_q[2*H+2 -: H] + {{(H-1){1'b0}}, s1_q[H+2]};
      assign sum    = {hi_sum, s1_q[H+1:2]};
    end else begin : g_full
      assign s1_d = {base + imm_in, jalr_in, chk_align_in};
      assign sum  = s1_q[XLEN+1:2];
    end
  endgenerate

  // JALR clears bit 0 before the alignment test sees the address.
  assign result = sum & ~{{(XLEN-1){1'b0}}, s1_q[1]};
  assign mis    = addr_misaligned(result[1:0], s1_q[0], IALIGN);
  assign s2_d   = {result, mis};

  msrv32_pipe_stage #(.W(S1W)) u_stage1 (
    .clk_i       (ms_riscv32_mp_clk_in),
    .rst_i       (ms_riscv32_mp_rst_in),
    .flush_i     (flush_in),
    .in_valid_i  (valid_in),
    .in_data_i   (s1_d),
    .in_ready_o  (ready_out),
    .out_ready_i (s2_in_ready),
    .out_valid_o (s1_valid),
    .out_data_o  (s1_q)
  );

  msrv32_pipe_stage #(.W(S2W)) u_stage2 (
    .clk_i       (ms_riscv32_mp_clk_in),
    .rst_i       (ms_riscv32_mp_rst_in),
    .flush_i     (flush_in),
    .in_valid_i  (s1_valid),
    .in_data_i   (s2_d),
    .in_ready_o  (s2_in_ready),
    .out_ready_i (ready_in),
    .out_valid_o (valid_out),
    .out_data_o  (s2_q)
  );

  assign iadder_out     = s2_q[XLEN:1];
  assign misaligned_out = s2_q[0];

endmodule

// File: tb/tb_msrv32_iadder_pipe.sv
// tb/tb_msrv32_iadder_pipe.sv - scoreboard bench for msrv32_iadder_pipe (IALIGN=4 split, IALIGN=2 full)
module tb_msrv32_iadder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc, rs1, imm;
  logic        src, jalr, chk, valid_in, flush, ready_in;

  logic        ro_a, vo_a, mis_a;
  logic [31:0] out_a;
  logic        ro_b, vo_b, mis_b;
  logic [31:0] out_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit bp_mode = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        mis;
    int          cyc;
    bit          strict;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msrv32_iadder_pipe #(.XLEN(32), .IALIGN(4), .SPLIT_ADD(1)) u_dut_a (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .pc_in                (pc),
    .rs_1_in              (rs1),
    .imm_in               (imm),
    .iadder_src_in        (src),
    .jalr_in              (jalr),
    .chk_align_in         (chk),
    .valid_in             (valid_in),
    .ready_out            (ro_a),
    .flush_in             (flush),
    .iadder_out           (out_a),
    .misaligned_out       (mis_a),
    .valid_out            (vo_a),
    .ready_in             (ready_in)
  );

  msrv32_iadder_pipe #(.XLEN(32), .IALIGN(2), .SPLIT_ADD(0)) u_dut_b (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .pc_in                (pc),
    .rs_1_in              (rs1),
    .imm_in               (imm),
    .iadder_src_in        (src),
    .jalr_in              (jalr),
    .chk_align_in         (chk),
    .valid_in             (valid_in),
    .ready_out            (ro_b),
    .flush_in             (flush),
    .iadder_out           (out_b),
    .misaligned_out       (mis_b),
    .valid_out            (vo_b),
    .ready_in             (ready_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model evaluated from the inputs that are about to be captured.
  always @(negedge clk) begin
    logic [31:0] a;
    exp_t e;
    if (rst || flush) begin
      qa.delete();
      qb.delete();
    end else begin
      check("a_out_event", 32'(vo_a && ready_in), 32'(vo_a && ready_in && qa.size() != 0));
      if (vo_a && ready_in && qa.size() != 0) begin
        e = qa.pop_front();
        check("a_addr", out_a, e.addr);
        check("a_mis", 32'(mis_a), 32'(e.mis));
        if (e.strict) check("a_latency", 32'(cyc - e.cyc), 32'd2);
      end
      check("b_out_event", 32'(vo_b && ready_in), 32'(vo_b && ready_in && qb.size() != 0));
      if (vo_b && ready_in && qb.size() != 0) begin
        e = qb.pop_front();
        check("b_addr", out_b, e.addr);
        check("b_mis", 32'(mis_b), 32'(e.mis));
        if (e.strict) check("b_latency", 32'(cyc - e.cyc), 32'd2);
      end
      a = (src ? rs1 : pc) + imm;
      if (jalr) a[0] = 1'b0;
      if (valid_in && ro_a) begin
        e.addr = a; e.mis = chk && (a[1:0] != 2'b00); e.cyc = cyc; e.strict = !bp_mode;
        qa.push_back(e);
      end
      if (valid_in && ro_b) begin
        e.addr = a; e.mis = chk && a[0]; e.cyc = cyc; e.strict = !bp_mode;
        qb.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] p, input logic [31:0] r, input logic [31:0] i,
                         input logic s, input logic j, input logic c);
    pc = p; rs1 = r; imm = i; src = s; jalr = j; chk = c; valid_in = 1'b1;
  endtask

  // Leaves valid_in high so consecutive calls form back-to-back requests.
  task automatic send(input logic [31:0] p, input logic [31:0] r, input logic [31:0] i,
                      input logic s, input logic j, input logic c);
    logic acc;
    acc = 1'b0;
    set_req(p, r, i, s, j, c);
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = ro_a;
      step();
    end
    check("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    valid_in = 1'b0;
    ready_in = 1'b1;
    for (int n = 0; n < 30 && (qa.size() + qb.size()) != 0; n++) step();
    check("drain_empty", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] hold;
    pc = '0; rs1 = '0; imm = '0; src = 1'b0; jalr = 1'b0; chk = 1'b0;
    valid_in = 1'b0; flush = 1'b0; ready_in = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_a", 32'(vo_a), 32'd0);
    check("rst_ready_a", 32'(ro_a), 32'd1);
    check("rst_out_a", out_a, 32'd0);
    check("rst_mis_a", 32'(mis_a), 32'd0);
    check("rst_valid_b", 32'(vo_b), 32'd0);
    check("rst_out_b", out_b, 32'd0);
    rst = 1'b0;
    step();

    send(32'h0000_1000, 32'h0, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    drain();
    send(32'h0, 32'h0000_2003, 32'h0, 1'b1, 1'b1, 1'b1);
    drain();
    send(32'h0000_FFFF, 32'h0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send(32'hFFFF_FFFC, 32'h0, 32'h0000_0008, 1'b0, 1'b0, 1'b1);
    drain();

    // Full-rate streaming: ready_out must never drop.
    for (int k = 0; k < 24; k++) begin
      set_req($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      check("stream_ready", 32'(ro_a), 32'd1);
      step();
    end
    drain();

    // Random traffic and backpressure; ordering and content checked by the scoreboard.
    bp_mode = 1'b1;
    for (int k = 0; k < 60; k++) begin
      set_req($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      valid_in = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Three back-to-back requests against a stalled sink.
    ready_in = 1'b0;
    send(32'h0000_0100, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0200, 32'h0, 32'h6, 1'b0, 1'b0, 1'b1);
    set_req(32'h0000_0300, 32'h0, 32'h8, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("bp_ready_low", 32'(ro_a), 32'd0);
    check("bp_valid", 32'(vo_a), 32'd1);
    hold = out_a;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      check("bp_ready_held", 32'(ro_a), 32'd0);
      check("bp_out_stable", out_a, hold);
    end
    step();
    ready_in = 1'b1;
    send(32'h0000_0300, 32'h0, 32'h8, 1'b0, 1'b0, 1'b1);
    drain();
    bp_mode = 1'b0;

    // Flush with two in flight and a same-cycle request.
    ready_in = 1'b0;
    send(32'h0000_0400, 32'h0, 32'h1, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0500, 32'h0, 32'h2, 1'b0, 1'b0, 1'b1);
    set_req(32'h0000_0600, 32'h0, 32'h3, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid_in = 1'b0;
    check("flush_valid_a", 32'(vo_a), 32'd0);
    check("flush_valid_b", 32'(vo_b), 32'd0);
    check("flush_ready", 32'(ro_a), 32'd1);
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flush_no_stale", 32'(vo_a || vo_b), 32'd0);
      step();
    end

    // Reset with a full pipeline, then a clean request.
    ready_in = 1'b0;
    bp_mode = 1'b1;
    send(32'h0000_0700, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0800, 32'h0, 32'h2, 1'b0, 1'b0, 1'b0);
    valid_in = 1'b0;
    bp_mode = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid_a", 32'(vo_a), 32'd0);
    check("arst_valid_b", 32'(vo_b), 32'd0);
    check("arst_ready", 32'(ro_a), 32'd1);
    step();
    rst = 1'b0;
    ready_in = 1'b1;
    send(32'h0000_0900, 32'h0000_0001, 32'h0000_0020, 1'b1, 1'b0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
